servo_trajectory_sequencer: RTL and testbench

Sequencer that walks the three-axis servo waypoint ROM from address 0 to a programmable last address. It holds each waypoint for a programmable number of clock ticks, and optionally loops. It drives the ROM chip-enable, read-enable and address, and latches the combinational X/Y/Z data into registered position outputs. Those outputs feed the servo PWM generators.

---
 rtl/servo_trajectory_sequencer.sv | 105 ++++++++++
 tb/tb_servo_trajectory_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/servo_trajectory_sequencer.sv
// Waypoint sequencer for the three-axis servo ROM. It walks addresses 0..last,
// holds each waypoint for a programmable dwell, and can optionally loop.
module servo_trajectory_sequencer #(
  parameter int DATA_WIDTH    = 10,
  parameter int ADDRESS_WIDTH = 8,
  parameter int DWELL_WIDTH   = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic [ADDRESS_WIDTH-1:0] last_addr,
  input  logic [DWELL_WIDTH-1:0]   dwell_ticks,
  output logic                     rom_ce,
  output logic                     rom_read_en,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_data_x,
  input  logic [DATA_WIDTH-1:0]    rom_data_y,
  input  logic [DATA_WIDTH-1:0]    rom_data_z,
  output logic [DATA_WIDTH-1:0]    pos_x,
  output logic [DATA_WIDTH-1:0]    pos_y,
  output logic [DATA_WIDTH-1:0]    pos_z,
  output logic                     pos_valid,
  output logic                     busy,
  output logic                     done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]               state;
  logic [DWELL_WIDTH-1:0]   dwell_cnt;
  logic [DWELL_WIDTH-1:0]   cfg_dwell;
  logic [ADDRESS_WIDTH-1:0] cfg_last;
  logic                     cfg_loop;
  logic [DWELL_WIDTH-1:0]   hold_load;

  // A dwell of zero is treated as one, so the hold phase always lasts at least a cycle.
  assign hold_load = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_WIDTH'(1);

  assign rom_ce      = (state == ST_FETCH);
  assign rom_read_en = (state == ST_FETCH);
  assign busy        = (state == ST_FETCH) || (state == ST_HOLD);
  assign done        = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rom_addr  <= '0;
      pos_x     <= '0;
      pos_y     <= '0;
      pos_z     <= '0;
      pos_valid <= 1'b0;
      dwell_cnt <= '0;
      cfg_dwell <= '0;
      cfg_last  <= '0;
      cfg_loop  <= 1'b0;
    end else begin
      pos_valid <= 1'b0;
      // Stop outranks everything, including a simultaneous start and a pending FETCH latch.
      if (stop) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              cfg_last  <= last_addr;
              cfg_dwell <= dwell_ticks;
              cfg_loop  <= loop_en;
              rom_addr  <= '0;
              state     <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            pos_x     <= rom_data_x;
            pos_y     <= rom_data_y;
            pos_z     <= rom_data_z;
            pos_valid <= 1'b1;
            dwell_cnt <= hold_load;
            state     <= ST_HOLD;
          end
          ST_HOLD: begin
            if (dwell_cnt == '0) begin
              if (rom_addr != cfg_last) begin
                rom_addr <= rom_addr + ADDRESS_WIDTH'(1);
                state    <= ST_FETCH;
              end else if (cfg_loop) begin
                rom_addr <= '0;
                state    <= ST_FETCH;
              end else begin
                state <= ST_DONE;
              end
            end else begin
              dwell_cnt <= dwell_cnt - DWELL_WIDTH'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_servo_trajectory_sequencer.sv
// Scoreboard bench for servo_trajectory_sequencer: stimulus queues the expected
// waypoint and arrival cycle, and a negedge monitor checks each pos_valid pulse.
module tb_servo_trajectory_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [7:0]  last_addr = '0;
  logic [23:0] dwell_ticks = '0;
  logic        rom_ce, rom_read_en;
  logic [7:0]  rom_addr;
  logic [9:0]  rom_data_x, rom_data_y, rom_data_z;
  logic [9:0]  pos_x, pos_y, pos_z;
  logic        pos_valid, busy, done;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] z;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   ce_cnt  = 0;
  int   pv_cnt  = 0;

  servo_trajectory_sequencer #(
    .DATA_WIDTH(10), .ADDRESS_WIDTH(8), .DWELL_WIDTH(24)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .last_addr(last_addr), .dwell_ticks(dwell_ticks),
    .rom_ce(rom_ce), .rom_read_en(rom_read_en), .rom_addr(rom_addr),
    .rom_data_x(rom_data_x), .rom_data_y(rom_data_y), .rom_data_z(rom_data_z),
    .pos_x(pos_x), .pos_y(pos_y), .pos_z(pos_z),
    .pos_valid(pos_valid), .busy(busy), .done(done)
  );

  // ROM model: x = i, y = i + 0x100, z = 0x3FF - i
  assign rom_data_x = {2'b00, rom_addr};
  assign rom_data_y = {2'b00, rom_addr} + 10'h100;
  assign rom_data_z = 10'h3FF - {2'b00, rom_addr};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rom_ce) ce_cnt++;
    if (pos_valid) begin
      pv_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_pos_valid", 32'(pos_x), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pos_x", 32'(pos_x), 32'(e.x));
        chk("pos_y", 32'(pos_y), 32'(e.y));
        chk("pos_z", 32'(pos_z), 32'(e.z));
        chk("pos_valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic push_wp(input int addr, input int at);
    exp_t e;
    e.x = 10'(addr);
    e.y = 10'(addr + 'h100);
    e.z = 10'('h3FF - addr);
    e.cyc = at;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_start(input logic [7:0] la, input logic [23:0] dw, input logic lp,
                          output int s);
    tick();
    last_addr = la;
    dwell_ticks = dw;
    loop_en = lp;
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_pos_x"}, 32'(pos_x), 0);
    chk({tag, "_pos_y"}, 32'(pos_y), 0);
    chk({tag, "_pos_z"}, 32'(pos_z), 0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
    chk({tag, "_ctrl"}, {27'd0, rom_ce, rom_read_en, pos_valid, busy, done}, 0);
  endtask

  initial begin
    int s;
    // Reset and idle
    repeat (3) tick();
    check_cleared("reset");
    rst = 1'b0;
    ce_cnt = 0;
    repeat (10) tick();
    chk("idle_rom_ce_count", 32'(ce_cnt), 0);
    chk("idle_busy", 32'(busy), 0);

    // Single pass: last=3, dwell=4, period 5
    ce_cnt = 0;
    do_start(8'd3, 24'd4, 1'b0, s);
    for (int i = 0; i < 4; i++) push_wp(i, s + 2 + 5 * i);
    wait_until(s + 20);
    chk("pass_done_before", 32'(done), 0);
    tick();
    chk("pass_done_at_21", 32'(done), 1);
    chk("pass_busy_at_21", 32'(busy), 0);
    chk("pass_fetch_cycles", 32'(ce_cnt), 4);
    chk("pass_queue_drained", 32'(q.size()), 0);

    // Loop with dwell=0 between addresses 0 and 1, period 2
    do_start(8'd1, 24'd0, 1'b1, s);
    for (int i = 0; i < 8; i++) push_wp(i % 2, s + 2 + 2 * i);
    wait_until(s + 15);
    chk("loop_done_low", 32'(done), 0);
    chk("loop_busy", 32'(busy), 1);
    wait_until(s + 16);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (6) tick();
    chk("loop_stopped_busy", 32'(busy), 0);
    chk("loop_queue_drained", 32'(q.size()), 0);

    // Stop and start together mid-HOLD at address 2
    do_start(8'd5, 24'd4, 1'b0, s);
    for (int i = 0; i < 3; i++) push_wp(i, s + 2 + 5 * i);
    wait_until(s + 13);
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("stop_busy", 32'(busy), 0);
    chk("stop_done", 32'(done), 0);
    chk("stop_pos_x_held", 32'(pos_x), 2);
    chk("stop_rom_addr_held", 32'(rom_addr), 2);
    repeat (10) tick();
    chk("stop_idle_still", 32'(busy), 0);
    chk("stop_queue_drained", 32'(q.size()), 0);

    // Start while busy is ignored: last=5, dwell=2, period 3
    do_start(8'd5, 24'd2, 1'b0, s);
    for (int i = 0; i < 6; i++) push_wp(i, s + 2 + 3 * i);
    wait_until(s + 4);
    last_addr = 8'd1;
    dwell_ticks = 24'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_until(s + 18);
    chk("busy_start_not_done_yet", 32'(done), 0);
    wait_until(s + 19);
    chk("busy_start_done", 32'(done), 1);
    chk("busy_start_final_x", 32'(pos_x), 5);
    chk("busy_start_queue_drained", 32'(q.size()), 0);

    // Asynchronous reset between clock edges
    do_start(8'd3, 24'd4, 1'b0, s);
    for (int i = 0; i < 4; i++) push_wp(i, s + 2 + 5 * i);
    wait_until(s + 9);
    #2;
    rst = 1'b1;
    #1;
    check_cleared("async_rst");
    q.delete();
    tick();
    rst = 1'b0;

    // Full address range, dwell=1, period 2
    pv_cnt = 0;
    do_start(8'd255, 24'd1, 1'b0, s);
    for (int i = 0; i < 256; i++) push_wp(i, s + 2 + 2 * i);
    wait_until(s + 515);
    chk("full_pulse_count", 32'(pv_cnt), 256);
    chk("full_done", 32'(done), 1);
    chk("full_rom_addr", 32'(rom_addr), 32'hFF);
    chk("full_pos_x", 32'(pos_x), 32'hFF);
    chk("full_queue_drained", 32'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
